// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : writeback_arbiter
// Purpose : Shares the register-file write port between the pipeline (A) and
//           a buffered multi-cycle unit (B), with a bounded B starvation.
// Rev     : 1.0
// ============================================================================
module writeback_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH     = 2,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      A_VALID,
    input  logic [REG_ADDR_WIDTH-1:0] A_RD,
    input  logic [DATA_WIDTH-1:0]     A_DATA,
    output logic                      STALL_PIPE,
    input  logic                      B_VALID,
    input  logic [REG_ADDR_WIDTH-1:0] B_RD,
    input  logic [DATA_WIDTH-1:0]     B_DATA,
    output logic                      B_READY,
    output logic                      WB_WE,
    output logic [REG_ADDR_WIDTH-1:0] WB_RD,
    output logic [DATA_WIDTH-1:0]     WB_DATA,
    output logic                      WB_SRC
);

    localparam int c_ptr_w  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w  = $clog2(FIFO_DEPTH + 1);
    localparam int c_wait_w = $clog2(STARVE_LIMIT + 1);
    localparam int c_ent_w  = REG_ADDR_WIDTH + DATA_WIDTH;

    localparam logic [c_cnt_w-1:0]  c_depth    = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(STARVE_LIMIT - 1);

    typedef enum logic [0:0] {
        ST_NORMAL  = 1'b0,
        ST_FORCE_B = 1'b1
    } state_t;

    state_t                      r_state;
    logic [c_wait_w-1:0]         r_wait;
    logic [c_cnt_w-1:0]          r_count;
    logic [c_ptr_w-1:0]          r_rd_ptr;
    logic [c_ptr_w-1:0]          r_wr_ptr;
    logic [c_ent_w-1:0]          r_mem [FIFO_DEPTH];

    logic                        r_wb_we;
    logic [REG_ADDR_WIDTH-1:0]   r_wb_rd;
    logic [DATA_WIDTH-1:0]       r_wb_data;
    logic                        r_wb_src;

    logic                        w_empty;
    logic                        w_b_ready;
    logic                        w_push;
    logic                        w_a_win;
    logic                        w_b_win;
    logic [c_ent_w-1:0]          w_head;
    logic [REG_ADDR_WIDTH-1:0]   w_head_rd;
    logic [DATA_WIDTH-1:0]       w_head_data;

    assign w_empty     = (r_count == '0);
    assign w_b_ready   = !RESET && (r_count < c_depth);
    assign w_push      = B_VALID && w_b_ready;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_rd   = w_head[DATA_WIDTH +: REG_ADDR_WIDTH];
    assign w_head_data = w_head[DATA_WIDTH-1:0];

    // A forced slot ignores A entirely; the pipeline re-presents it next cycle.
    always_comb begin
        w_a_win = 1'b0;
        w_b_win = 1'b0;
        if (r_state == ST_FORCE_B) begin
            w_b_win = !w_empty;
        end else if (A_VALID) begin
            w_a_win = 1'b1;
        end else begin
            w_b_win = !w_empty;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {B_RD, B_DATA};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= ST_NORMAL;
            r_wait    <= '0;
            r_count   <= '0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_wb_we   <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
            r_wb_src  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_b_win) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_b_win})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase

            case (r_state)
                ST_NORMAL: begin
                    if (w_a_win && !w_empty) begin
                        if (r_wait == c_wait_max) begin
                            r_state <= ST_FORCE_B;
                            r_wait  <= '0;
                        end else begin
                            r_wait <= r_wait + c_wait_w'(1);
                        end
                    end else begin
                        r_wait <= '0;
                    end
                end
                default: begin
                    r_state <= ST_NORMAL;
                    r_wait  <= '0;
                end
            endcase

            // rd 0 slots are consumed without a register-file write.
            if (w_a_win) begin
                r_wb_we   <= |A_RD;
                r_wb_rd   <= A_RD;
                r_wb_data <= A_DATA;
                r_wb_src  <= 1'b0;
            end else if (w_b_win) begin
                r_wb_we   <= |w_head_rd;
                r_wb_rd   <= w_head_rd;
                r_wb_data <= w_head_data;
                r_wb_src  <= 1'b1;
            end else begin
                r_wb_we   <= 1'b0;
            end
        end
    end

    assign STALL_PIPE = (r_state == ST_FORCE_B);
    assign B_READY    = w_b_ready;
    assign WB_WE      = r_wb_we;
    assign WB_RD      = r_wb_rd;
    assign WB_DATA    = r_wb_data;
    assign WB_SRC     = r_wb_src;

endmodule
`default_nettype wire

// File: doc/writeback_arbiter.md
# writeback_arbiter

Arbitrates the single register-file write port between the in-order pipeline result (requester A) and a multi-cycle execution unit (requester B, e.g. mul/div). It buffers B results in a small FIFO, gives A priority, and enforces a starvation bound by stalling the pipeline for one cycle. It sits at the head of the write-back stage. It drives the registered write enable, destination register, data, and source-select to the register file and the write-back multiplexer.

## Interface
- DATA_WIDTH, 32, result/data bus width
- REG_ADDR_WIDTH, 5, register index width
- FIFO_DEPTH, 2, B result buffer entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive B losses before forced B slot (≥1)

- CLK  input  1  clock, all state on rising edge
- RESET  input  1  synchronous, active-high reset
- A_VALID  input  1  pipeline result valid this cycle
- A_RD  input  REG_ADDR_WIDTH  pipeline destination register
- A_DATA  input  DATA_WIDTH  pipeline result
- STALL_PIPE  output  1  pipeline must hold its A request; A ignored while high
- B_VALID  input  1  multi-cycle unit result valid
- B_RD  input  REG_ADDR_WIDTH  multi-cycle destination register
- B_DATA  input  DATA_WIDTH  multi-cycle result
- B_READY  output  1  FIFO can accept; transfer when B_VALID && B_READY
- WB_WE  output  1  register-file write enable (registered)
- WB_RD  output  REG_ADDR_WIDTH  write address (registered)
- WB_DATA  output  DATA_WIDTH  write data (registered)
- WB_SRC  output  1  winner of the committed slot: 0 = A, 1 = B; feeds mux SELECT

## Operation
- Single clock, synchronous active-high reset; FIFO, counter, state machine, and WB_* registers all reset together.
- B_READY = !RESET && (count < FIFO_DEPTH). It is derived from registered count only. A pop in the same cycle does not raise it.
- No enqueue bypass: an entry written at edge t is eligible to win from cycle t onward (after that edge).
- States:
  - NORMAL: STALL_PIPE=0.
  - FORCE_B: STALL_PIPE=1, Moore output.
- Arbitration in NORMAL:
  - If A_VALID, A wins.
  - Else if FIFO non-empty, B head wins and is popped.
  - Else no write.
- Arbitration in FORCE_B: B head wins and is popped; A_VALID is ignored and the pipeline re-presents A next cycle.
- Wait counter:
  - In NORMAL, increments when A wins while FIFO is non-empty.
  - Cleared when B wins or FIFO is empty.
- Transitions:
  - NORMAL → FORCE_B when the counter equals STARVE_LIMIT-1 and B loses again.
  - FORCE_B → NORMAL unconditionally after its one B write. The counter clears.
- FORCE_B is entered only with a non-empty FIFO, so it always performs a B write.
- Winner slot: WB_RD, WB_DATA, and WB_SRC take the winner's values. WB_WE=1 unless the winner's rd == 0; an rd=0 slot is consumed with WB_WE=0.
- No winner: WB_WE=0; WB_RD, WB_DATA, and WB_SRC hold their previous values.
- Ordering: the issue-stage scoreboard guarantees no A write to an rd with an outstanding B result. The arbiter performs no rd comparison.
- FIFO is strictly in-order: B results commit in acceptance order.

## Timing
- Reset values:
  - WB_WE=0, WB_RD=0, WB_DATA=0, WB_SRC=0, STALL_PIPE=0.
  - FIFO empty, counter 0, state NORMAL.
  - B_READY=0 while RESET is high, 1 in the first cycle after.
- A latency: A request in cycle t → WB_* valid in cycle t+1.
- B latency: minimum 2 cycles (accept at t, win at t+1, WB_* at t+2).
- Simultaneous enqueue and pop with count=FIFO_DEPTH-1: allowed; count unchanged.
- Full FIFO: B_READY=0; B must hold B_VALID and its data.
- Worst-case B wait with A saturating: STARVE_LIMIT losses, then one FORCE_B cycle.
- RESET mid-operation:
  - FIFO contents are discarded.
  - A forced slot in progress is abandoned.
  - Outputs take reset values at the next edge.

## Test plan
- Reset: hold RESET 2 cycles with A_VALID=1, B_VALID=1 → WB_WE=0, B_READY=0, STALL_PIPE=0; no FIFO entry accepted.
- A only: A_VALID=1, A_RD=5, A_DATA=0xDEADBEEF at t → WB_WE=1, WB_RD=5, WB_DATA=0xDEADBEEF, WB_SRC=0 at t+1.
- rd=0 write: A_RD=0 → slot consumed with WB_WE=0. Same for a B entry with rd=0.
- B only, back-to-back: B results (rd 3, 0x11) and (rd 4, 0x22) in consecutive cycles, A idle → WB_SRC=1 writes at t+2 and t+3, in order. B_READY stays 1.
- Starvation, STARVE_LIMIT=4: A_VALID=1 continuously, one B entry queued → 4 A writes, then STALL_PIPE=1 for exactly one cycle. During that cycle the B head wins and its write appears the next cycle. A resumes after.
- FIFO full: A saturating, B presents 3 results with FIFO_DEPTH=2 → B_READY=0 after 2 accepts. The third is accepted only after a pop, and all three commit in order.
